// File: rtl/uart_tx_queue_pkg.sv
// Shared state encoding and frame-timing helpers for the UART transmit queue.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } txq_state_e;

    // Longest frame the pacing timer must count; sizes the timer register.
    localparam int unsigned MAX_FRAME_CYCLES = 1 << 20;
    localparam int          TIMER_W          = $clog2(MAX_FRAME_CYCLES);

    function automatic int unsigned frame_cycles(input int unsigned baud_div,
                                                 input int unsigned idle_gap);
        return 10 * (baud_div + 1) + 1 + idle_gap;
    endfunction

endpackage

// File: rtl/uart_tx_queue_if.sv
// Byte valid/ready handshake into the UART transmit queue.
interface uart_tx_queue_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_queue_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head of queue is read combinationally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and frame pacer feeding the UART transmitter.
// Optional drop counter on refused writes: define UART_TXQ_DROP_CNT_EN.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 108,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned IDLE_GAP = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_tx_queue_if.slave          s,
    input  logic                    flush,
    output logic [7:0]              tdata,
    output logic                    tdata_req,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    busy
`ifdef UART_TXQ_DROP_CNT_EN
    ,
    output logic [7:0]              drop_cnt
`endif
);
    localparam int unsigned        FRAME_CYCLES = frame_cycles(BAUD_DIV, IDLE_GAP);
    localparam logic [TIMER_W-1:0] TIMER_LOAD   = TIMER_W'(FRAME_CYCLES - 2);

    txq_state_e         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [7:0]         tdata_q, tdata_d;
    logic               tdata_req_q, tdata_req_d;

    logic               full, empty, push, pop;
    logic [7:0]         head;

    assign s.s_ready = !full && !flush;
    assign push      = s.s_valid && s.s_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (s.s_data),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .rd_data (head)
    );

    // The head is popped on the edge into SEND so tdata and tdata_req are
    // both registered and valid together in the SEND cycle.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty && !flush) begin
                    state_d = ST_SEND;
                    pop     = 1'b1;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
                timer_d = TIMER_LOAD;
            end
            ST_WAIT: begin
                if (timer_q == '0) begin
                    if (!empty && !flush) begin
                        state_d = ST_SEND;
                        pop     = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tdata_d     = pop ? head : tdata_q;
        tdata_req_d = pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            tdata_q     <= 8'h00;
            tdata_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            tdata_q     <= tdata_d;
            tdata_req_q <= tdata_req_d;
        end
    end

    assign tdata     = tdata_q;
    assign tdata_req = tdata_req_q;
    assign busy      = (state_q != ST_IDLE) || !empty;

`ifdef UART_TXQ_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (s.s_valid && !s.s_ready && (drop_cnt_q != 8'hFF))
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) drop_cnt_q <= 8'h00;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: expected bytes and request cycles are
// queued when pushed and compared when tdata_req fires.
module tb_uart_tx_queue;

    localparam longint FRAME = 1091;  // 10*(108+1)+1+0

    logic       clk;
    logic       rst;
    logic       flush;
    logic [7:0] tdata;
    logic       tdata_req;
    logic [4:0] level;
    logic       busy;
`ifdef UART_TXQ_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    uart_tx_queue_if bus();

    uart_tx_queue #(
        .BAUD_DIV (108),
        .DEPTH    (16),
        .IDLE_GAP (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s         (bus),
        .flush     (flush),
        .tdata     (tdata),
        .tdata_req (tdata_req),
        .level     (level),
        .busy      (busy)
`ifdef UART_TXQ_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    typedef struct {
        logic [7:0] data;
        longint     at;
    } exp_t;

    exp_t   exp_q[$];
    longint cyc        = 0;
    longint last_sched = -100000;
    int     total_cnt  = 0;
    int     bad_cnt    = 0;
    logic   prev_req   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        total_cnt++;
        if (got != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_req <= 1'b0;
        end else begin
            if (tdata_req) begin
                exp_t e;
                chk("req_width", prev_req, 0);
                chk("req_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("tdata", tdata, e.data);
                    chk("req_cycle", cyc, e.at);
                end
            end
            prev_req <= tdata_req;
        end
    end

    task automatic push_byte(input logic [7:0] d, input bit sched, input bit exp_ready,
                             output longint n);
        longint p;
        @(negedge clk);
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        #1;
        chk("s_ready", bus.s_ready, exp_ready);
        n = cyc;
        if (exp_ready && sched) begin
            p = (n + 2 > last_sched + FRAME) ? n + 2 : last_sched + FRAME;
            last_sched = p;
            exp_q.push_back('{d, p});
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_until(input longint t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("drain_done", (exp_q.size() == 0) && !busy, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_sched = -100000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        longint n;
        longint p1;
        rst         = 1'b1;
        flush       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_sched = -100000;
        #1;
        chk("rst_req", tdata_req, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.s_ready, 1);

        // single byte
        push_byte(8'hA5, 1, 1, n);
        wait_until(n + 2 + FRAME - 1);
        chk("busy_hold", busy, 1);
        wait_until(n + 2 + FRAME);
        chk("busy_fall", busy, 0);

        // three bytes back-to-back
        push_byte(8'h11, 1, 1, n);
        push_byte(8'h22, 1, 1, n);
        push_byte(8'h33, 1, 1, n);
        drain(5000);

        // overflow: 17 pushes while the first frame is in WAIT
        push_byte(8'h40, 1, 1, n);
        wait_until(n + 10);
        for (int i = 0; i < 17; i++) push_byte(8'h80 + 8'(i), 1, i < 16, n);
        chk("ovf_level", level, 16);
        chk("ovf_ready", bus.s_ready, 0);
`ifdef UART_TXQ_DROP_CNT_EN
        chk("drop_cnt", drop_cnt, 1);
`endif
        p1 = exp_q[0].at;
        wait_until(p1 - 1);
        chk("full_before_pop", bus.s_ready, 0);
        wait_until(p1);
        chk("ready_after_pop", bus.s_ready, 1);
        chk("level_after_pop", level, 15);
        drain(25000);

        // flush with five queued mid-WAIT
        push_byte(8'h55, 1, 1, n);
        wait_until(n + 20);
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i), 0, 1, n);
        @(negedge clk);
        chk("pre_flush_level", level, 5);
        flush = 1'b1;
        #1;
        chk("flush_ready", bus.s_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_busy", busy, 1);
        drain(3000);

        // reset mid-WAIT, then a fresh byte must go out with no residual delay
        push_byte(8'h77, 1, 1, n);
        wait_until(n + 100);
        do_reset();
        #1;
        chk("rst2_busy", busy, 0);
        chk("rst2_tdata", tdata, 0);
        chk("rst2_level", level, 0);
        push_byte(8'h5A, 1, 1, n);
        drain(3000);

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

- Byte queue and frame pacer that sits directly upstream of the UART transmitter.
- Accepts bytes from on-chip logic over a valid/ready handshake and buffers them in a FIFO.
- Issues one single-cycle `tdata_req` per byte, with `tdata`, spaced so that the transmitter is always back in IDLE when the request arrives. The transmitter has no ready output, so pacing is by a frame timer.

## Interface
Parameters:
- `BAUD_DIV`, 108: transmitter baud divisor; one bit period = `BAUD_DIV`+1 clocks (100 MHz / 921.6 kbps).
- `DEPTH`, 16: FIFO depth in bytes; power of two, ≥2.
- `IDLE_GAP`, 0: extra idle clocks inserted between frames.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `s_data`  in  8: byte to queue.
- `s_valid`  in  1: `s_data` valid.
- `s_ready`  out  1: queue can accept; a transfer occurs when `s_valid`&&`s_ready`.
- `flush`  in  1: discard all queued bytes.
- `tdata`  out  8: byte to the transmitter; registered, holds its value between requests.
- `tdata_req`  out  1: one-cycle start pulse to the transmitter.
- `level`  out  $clog2(DEPTH)+1: bytes currently queued.
- `busy`  out  1: FIFO non-empty or frame in progress.
- `drop_cnt`  out  8: only with `UART_TXQ_DROP_CNT_EN`.

## Operation
- `FRAME_CYCLES` = 10*(`BAUD_DIV`+1)+1+`IDLE_GAP`. The default is 1091.
- FSM states and transitions:
  - IDLE: FIFO not empty → SEND.
  - SEND: lasts one cycle. Pops the head into `tdata`, asserts `tdata_req`, loads the timer with `FRAME_CYCLES`-2, then → WAIT.
  - WAIT: timer decrements each cycle. At 0 → SEND if the FIFO is non-empty, else → IDLE.
- Resulting spacing: consecutive `tdata_req` pulses are exactly `FRAME_CYCLES` apart while the FIFO stays non-empty.
- FIFO behaviour:
  - Pointers wrap modulo `DEPTH` with an extra wrap bit; full/empty come from pointer compare.
  - `level` = wr_ptr − rd_ptr, using `$clog2(DEPTH)`+1 bits.
- `s_ready` = !full && !flush. When full it stays low even in a SEND (pop) cycle; no write-through on full.
- A write into an empty FIFO in the same cycle as SEND cannot occur: SEND requires a non-empty FIFO.
- Push and pop in the same cycle: both take effect, and `level` is unchanged.
- `flush` (high for one cycle):
  - Next cycle: FIFO empty, `level`=0.
  - A frame already requested is not aborted; WAIT runs to completion and then → IDLE.
  - A pop scheduled in the same cycle as `flush` is suppressed, so no SEND occurs.
- `busy` = (state≠IDLE) || !empty.
- Reset clears state to IDLE, both pointers, the timer, and `drop_cnt`. Reset values: `tdata`=0x00, `tdata_req`=0, `s_ready`=1 (first cycle after reset), `level`=0, `busy`=0.
- `rst` must be asserted together with the transmitter's reset. A queue reset mid-frame with the transmitter still running is not supported.

## Timing
- Byte accepted at cycle n into an empty queue in IDLE: `tdata_req`=1 at cycle n+2, with `tdata` valid in the same cycle.
- Pulse width: `tdata_req` is exactly 1 cycle and is never asserted on consecutive cycles.
- `level` updates the cycle after the push/pop edge.
- `s_ready` deasserts the cycle after the write that fills the FIFO.
- `s_ready` reasserts the cycle after the pop from full.

## Configuration
- `UART_TXQ_DROP_CNT_EN` defined:
  - `drop_cnt` port exists.
  - It increments on every cycle with `s_valid`=1 && `s_ready`=0 and saturates at 255.
  - It is cleared only by `rst`.
- Undefined: the port and counter are absent, and attempted writes when not ready are silently ignored (normal handshake).

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE/SEND/WAIT).
  - Function computing `FRAME_CYCLES` from `BAUD_DIV`/`IDLE_GAP`.
  - Timer width constant (`$clog2` of max frame).
- Sub-module `sync_fifo`:
  - Parameterised width/depth.
  - Ports: push, pop, flush, full, empty, level, rd_data.
  - Read data is head-of-queue, combinational from the array.
- The FSM, timer, and drop counter stay in `uart_tx_queue`.

## Test plan
- Reset: hold `rst` 2 cycles. Then expect `tdata_req`=0, `tdata`=0x00, `level`=0, `busy`=0, `s_ready`=1.
- Single byte 0xA5 accepted at cycle n: single `tdata_req` pulse at n+2 with `tdata`=0xA5. `busy` falls at n+2+1091.
- Bytes 0x11, 0x22, 0x33 back-to-back:
  - Pulses at n+2, n+1093, n+2184 in order.
  - With the transmitter attached, `uart_tx` shows three intact 10-bit frames.
- Overflow: push 17 bytes during WAIT.
  - `s_ready` is low once `level`=16.
  - The 17th byte is never sent.
  - `drop_cnt`=1 with `UART_TXQ_DROP_CNT_EN`.
- Flush with 5 queued mid-WAIT: `level`=0 the next cycle, and no further `tdata_req` after the current frame.
- Reset during WAIT, then push 0x5A at cycle m: `tdata_req` at m+2 with `tdata`=0x5A, with no residual timer delay.
